ctrl_unit: RTL and testbench

Instruction decoder for the RV32I core with Zicsr and machine-mode privileged support. It takes the 32-bit instruction word from the fetch/decode stage and produces flat control strobes for the ALU, register file write-back, branch/jump logic, load/store unit, CSR file and trap logic. Decode is purely combinational. A single clocked sticky flag records that an illegal instruction has been decoded.

---
 rtl/ctrl_pkg.sv | 68 ++++++
 rtl/ctrl_sys_decode.sv | 39 +++
 rtl/ctrl_unit.sv | 180 ++++++++++++++++++
 tb/tb_ctrl_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared decode constants and control bundles for ctrl_unit.
// Holds RV32I opcodes, ALU funct3 codes, SYSTEM funct12 codes, structs.
package ctrl_pkg;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_REG      = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  localparam logic [2:0] ADD  = 3'b000;
  localparam logic [2:0] SLL  = 3'b001;
  localparam logic [2:0] SLT  = 3'b010;
  localparam logic [2:0] SLTU = 3'b011;
  localparam logic [2:0] XOR  = 3'b100;
  localparam logic [2:0] SR   = 3'b101;
  localparam logic [2:0] OR   = 3'b110;
  localparam logic [2:0] AND  = 3'b111;

  localparam logic [11:0] ECALL  = 12'h000;
  localparam logic [11:0] EBREAK = 12'h001;
  localparam logic [11:0] MRET   = 12'h302;

  typedef struct packed {
    logic is_csr;
    logic csr_w;
    logic csr_set;
    logic csr_clr;
    logic csr_zimm;
    logic is_mret;
    logic exc_ecall;
    logic exc_break;
    logic illegal;
  } sys_t;

  typedef struct packed {
    logic [2:0] alu_op;
    logic alu_imm;
    logic alu_sub;
    logic alu_sra;
    logic rd_w;
    logic ld_upper;
    logic add_pc;
    logic jmp_reg;
    logic is_jmp;
    logic is_branch;
    logic is_load;
    logic is_store;
    logic is_fence;
    logic is_fencei;
    logic is_csr;
    logic csr_w;
    logic csr_set;
    logic csr_clr;
    logic csr_zimm;
    logic is_mret;
    logic exc_ecall;
    logic exc_break;
    logic exc_illegal;
  } ctrl_t;

endpackage

// File: rtl/ctrl_sys_decode.sv
// SYSTEM opcode group decode: ECALL/EBREAK/MRET and Zicsr CSR access.
// Ports: funct12, funct3 in; sys (sys_t bundle) out. Macro CTRL_UNIT_ZICSR_EN.
module ctrl_sys_decode
  import ctrl_pkg::*;
(
  input  logic [11:0] funct12,
  input  logic [2:0]  funct3,
  output sys_t        sys
);

  always_comb begin
    sys = '0;
    case (funct3)
      3'b000: begin
        case (funct12)
          ECALL:  sys.exc_ecall = 1'b1;
          EBREAK: sys.exc_break = 1'b1;
`ifdef CTRL_UNIT_ZICSR_EN
          MRET:   sys.is_mret = 1'b1;
`endif
          default: sys.illegal = 1'b1;
        endcase
      end
      3'b100: sys.illegal = 1'b1;
      default: begin
`ifdef CTRL_UNIT_ZICSR_EN
        sys.is_csr   = 1'b1;
        sys.csr_w    = (funct3[1:0] == 2'b01);
        sys.csr_set  = (funct3[1:0] == 2'b10);
        sys.csr_clr  = (funct3[1:0] == 2'b11);
        sys.csr_zimm = funct3[2];
`else
        sys.illegal = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/ctrl_unit.sv
// RV32I + Zicsr instruction decoder with a sticky illegal-instruction flag.
// Ports: clk, rst_n, inst in; ALU/WB/branch/LSU/CSR/trap strobes, illegal_seen out.
module ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] inst,
  output logic [2:0]      alu_op,
  output logic            alu_imm,
  output logic            alu_sub,
  output logic            alu_sra,
  output logic            rd_w,
  output logic            ld_upper,
  output logic            add_pc,
  output logic            jmp_reg,
  output logic            is_jmp,
  output logic            is_branch,
  output logic            is_load,
  output logic            is_store,
  output logic            is_fence,
  output logic            is_fencei,
  output logic            is_csr,
  output logic            csr_w,
  output logic            csr_set,
  output logic            csr_clr,
  output logic            csr_zimm,
  output logic            is_mret,
  output logic            exc_ecall,
  output logic            exc_break,
  output logic            exc_illegal,
  output logic            illegal_seen
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic       b30;
  sys_t       sys;
  ctrl_t      c;
  logic       ill;
  logic       unused;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign b30    = inst[30];
  assign unused = ^{inst[19:15], inst[11:7]};

  ctrl_sys_decode u_sys (
    .funct12 (inst[31:20]),
    .funct3  (f3),
    .sys     (sys)
  );

  always_comb begin
    c = '0;
    c.alu_op = f3;
    ill = 1'b0;
    case (opcode)
      OP_LUI: begin
        c.rd_w = 1'b1;
        c.ld_upper = 1'b1;
        c.alu_op = ADD;
      end
      OP_AUIPC: begin
        c.rd_w = 1'b1;
        c.add_pc = 1'b1;
        c.alu_op = ADD;
      end
      OP_JAL: begin
        c.rd_w = 1'b1;
        c.is_jmp = 1'b1;
        c.alu_op = ADD;
      end
      OP_JALR: begin
        if (f3 == ADD) begin
          c.rd_w = 1'b1;
          c.is_jmp = 1'b1;
          c.jmp_reg = 1'b1;
          c.alu_imm = 1'b1;
        end else begin
          ill = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (f3 == SLT || f3 == SLTU)
          ill = 1'b1;
        else
          c.is_branch = 1'b1;
      end
      OP_LOAD: begin
        if (f3 == 3'b011 || f3[2:1] == 2'b11) begin
          ill = 1'b1;
        end else begin
          c.rd_w = 1'b1;
          c.alu_imm = 1'b1;
          c.is_load = 1'b1;
          c.alu_op = ADD;
        end
      end
      OP_STORE: begin
        if (f3[2] || f3[1:0] == 2'b11) begin
          ill = 1'b1;
        end else begin
          c.alu_imm = 1'b1;
          c.is_store = 1'b1;
          c.alu_op = ADD;
        end
      end
      OP_IMM: begin
        c.rd_w = 1'b1;
        c.alu_imm = 1'b1;
        c.alu_sra = (f3 == SR) & b30;
      end
      OP_REG: begin
        c.rd_w = 1'b1;
        c.alu_sub = (f3 == ADD) & b30;
        c.alu_sra = (f3 == SR) & b30;
      end
      OP_MISC_MEM: begin
        case (f3)
          3'b000:  c.is_fence = 1'b1;
          3'b001:  c.is_fencei = 1'b1;
          default: ill = 1'b1;
        endcase
      end
      OP_SYSTEM: begin
        ill = sys.illegal;
        c.rd_w = sys.is_csr;
        c.is_csr = sys.is_csr;
        c.csr_w = sys.csr_w;
        c.csr_set = sys.csr_set;
        c.csr_clr = sys.csr_clr;
        c.csr_zimm = sys.csr_zimm;
        c.is_mret = sys.is_mret;
        c.exc_ecall = sys.exc_ecall;
        c.exc_break = sys.exc_break;
      end
      default: ill = 1'b1;
    endcase
    // Unrecognised encodings drop every strobe and force alu_op to 000.
    if (ill) begin
      c = '0;
      c.exc_illegal = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      illegal_seen <= 1'b0;
    else if (c.exc_illegal)
      illegal_seen <= 1'b1;
  end

  assign alu_op      = c.alu_op;
  assign alu_imm     = c.alu_imm;
  assign alu_sub     = c.alu_sub;
  assign alu_sra     = c.alu_sra;
  assign rd_w        = c.rd_w;
  assign ld_upper    = c.ld_upper;
  assign add_pc      = c.add_pc;
  assign jmp_reg     = c.jmp_reg;
  assign is_jmp      = c.is_jmp;
  assign is_branch   = c.is_branch;
  assign is_load     = c.is_load;
  assign is_store    = c.is_store;
  assign is_fence    = c.is_fence;
  assign is_fencei   = c.is_fencei;
  assign is_csr      = c.is_csr;
  assign csr_w       = c.csr_w;
  assign csr_set     = c.csr_set;
  assign csr_clr     = c.csr_clr;
  assign csr_zimm    = c.csr_zimm;
  assign is_mret     = c.is_mret;
  assign exc_ecall   = c.exc_ecall;
  assign exc_break   = c.exc_break;
  assign exc_illegal = c.exc_illegal;

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed self-checking bench for ctrl_unit.
// Decode vectors with hand-computed strobe words plus sticky-flag sequence.
module tb_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst = 32'hFFFF_FFFF;
  logic [2:0]  alu_op;
  logic alu_imm, alu_sub, alu_sra, rd_w, ld_upper, add_pc, jmp_reg;
  logic is_jmp, is_branch, is_load, is_store, is_fence, is_fencei;
  logic is_csr, csr_w, csr_set, csr_clr, csr_zimm, is_mret;
  logic exc_ecall, exc_break, exc_illegal, illegal_seen;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctrl_unit #(.XLEN(32)) dut (
    .clk (clk), .rst_n (rst_n), .inst (inst),
    .alu_op (alu_op), .alu_imm (alu_imm), .alu_sub (alu_sub),
    .alu_sra (alu_sra), .rd_w (rd_w), .ld_upper (ld_upper),
    .add_pc (add_pc), .jmp_reg (jmp_reg), .is_jmp (is_jmp),
    .is_branch (is_branch), .is_load (is_load), .is_store (is_store),
    .is_fence (is_fence), .is_fencei (is_fencei), .is_csr (is_csr),
    .csr_w (csr_w), .csr_set (csr_set), .csr_clr (csr_clr),
    .csr_zimm (csr_zimm), .is_mret (is_mret), .exc_ecall (exc_ecall),
    .exc_break (exc_break), .exc_illegal (exc_illegal),
    .illegal_seen (illegal_seen)
  );

  // Strobe word layout: alu_op[24:22], then one bit per strobe.
  localparam logic [24:0] IMM   = 25'd1 << 21;
  localparam logic [24:0] SUB   = 25'd1 << 20;
  localparam logic [24:0] SRA   = 25'd1 << 19;
  localparam logic [24:0] RDW   = 25'd1 << 18;
  localparam logic [24:0] LU    = 25'd1 << 17;
  localparam logic [24:0] APC   = 25'd1 << 16;
  localparam logic [24:0] JREG  = 25'd1 << 15;
  localparam logic [24:0] JMP   = 25'd1 << 14;
  localparam logic [24:0] BR    = 25'd1 << 13;
  localparam logic [24:0] LD    = 25'd1 << 12;
  localparam logic [24:0] ST    = 25'd1 << 11;
  localparam logic [24:0] FEN   = 25'd1 << 10;
  localparam logic [24:0] FENI  = 25'd1 << 9;
  localparam logic [24:0] CSR   = 25'd1 << 8;
  localparam logic [24:0] CW    = 25'd1 << 7;
  localparam logic [24:0] CS    = 25'd1 << 6;
  localparam logic [24:0] CC    = 25'd1 << 5;
  localparam logic [24:0] CZ    = 25'd1 << 4;
  localparam logic [24:0] MR    = 25'd1 << 3;
  localparam logic [24:0] ECL   = 25'd1 << 2;
  localparam logic [24:0] EBK   = 25'd1 << 1;
  localparam logic [24:0] ILL   = 25'd1;

  function automatic logic [24:0] op(input logic [2:0] f);
    return {f, 22'd0};
  endfunction

  logic [24:0] got;
  assign got = {alu_op, alu_imm, alu_sub, alu_sra, rd_w, ld_upper,
                add_pc, jmp_reg, is_jmp, is_branch, is_load, is_store,
                is_fence, is_fencei, is_csr, csr_w, csr_set, csr_clr,
                csr_zimm, is_mret, exc_ecall, exc_break, exc_illegal};

  task automatic chk_dec(input string tag, input logic [24:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (inst %h)",
             tag, got, exp, inst);
    end
  endtask

  task automatic chk_seen(input string tag, input logic exp);
    checks++;
    assert (illegal_seen === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, illegal_seen, exp);
    end
  endtask

  task automatic vec(input string tag, input logic [31:0] i,
                     input logic [24:0] exp);
    @(negedge clk);
    inst = i;
    #1;
    chk_dec(tag, exp);
  endtask

  logic [24:0] e_mret, e_csrrw, e_csrrsi, e_csrrc, e_csrrci;

  initial begin
`ifdef CTRL_UNIT_ZICSR_EN
    e_mret   = op(3'd0) | MR;
    e_csrrw  = op(3'd1) | RDW | CSR | CW;
    e_csrrsi = op(3'd6) | RDW | CSR | CS | CZ;
    e_csrrc  = op(3'd3) | RDW | CSR | CC;
    e_csrrci = op(3'd7) | RDW | CSR | CC | CZ;
`else
    e_mret   = ILL;
    e_csrrw  = ILL;
    e_csrrsi = ILL;
    e_csrrc  = ILL;
    e_csrrci = ILL;
`endif

    // Reset held with an illegal word present: decode live, flag stays 0.
    #1;
    chk_dec("rst_decode_ill", ILL);
    @(posedge clk);
    #1;
    chk_seen("rst_no_set", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    inst = 32'h0000_0013;
    @(posedge clk);
    #1;
    chk_seen("legal_no_set", 1'b0);

    // Sticky flag sequence.
    vec("all_ones", 32'hFFFF_FFFF, ILL);
    @(posedge clk);
    #1;
    chk_seen("seen_set", 1'b1);
    vec("addi_after", 32'h0000_0013, op(3'd0) | RDW | IMM);
    @(posedge clk);
    #1;
    chk_seen("seen_hold", 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_seen("seen_async_clr", 1'b0);
    chk_dec("decode_in_rst", op(3'd0) | RDW | IMM);
    #1;
    rst_n = 1'b1;

    // Decode table.
    vec("srai",     32'h4000_5013, op(3'd5) | RDW | IMM | SRA);
    vec("srli",     32'h0000_5013, op(3'd5) | RDW | IMM);
    vec("addi_b30", 32'h4000_0013, op(3'd0) | RDW | IMM);
    vec("sub",      32'h4000_0033, op(3'd0) | RDW | SUB);
    vec("sra",      32'h4000_5033, op(3'd5) | RDW | SRA);
    vec("and",      32'h0000_7033, op(3'd7) | RDW);
    vec("lw",       32'h0000_2003, op(3'd0) | RDW | IMM | LD);
    vec("lhu",      32'h0000_5003, op(3'd0) | RDW | IMM | LD);
    vec("ld_f3_3",  32'h0000_3003, ILL);
    vec("ld_f3_6",  32'h0000_6003, ILL);
    vec("sw",       32'h0000_2023, op(3'd0) | IMM | ST);
    vec("st_f3_3",  32'h0000_3023, ILL);
    vec("lui",      32'h1234_50B7, op(3'd0) | RDW | LU);
    vec("auipc",    32'h0000_5097, op(3'd0) | RDW | APC);
    vec("jal",      32'h0000_706F, op(3'd0) | RDW | JMP);
    vec("jalr",     32'h0000_8067, op(3'd0) | RDW | JMP | JREG | IMM);
    vec("jalr_f3",  32'h0000_1067, ILL);
    vec("beq",      32'h0000_0063, op(3'd0) | BR);
    vec("bltu",     32'h0000_6063, op(3'd6) | BR);
    vec("br_f3_2",  32'h0000_2063, ILL);
    vec("br_f3_3",  32'h0000_3063, ILL);
    vec("fence",    32'h0000_000F, op(3'd0) | FEN);
    vec("fencei",   32'h0000_100F, op(3'd1) | FENI);
    vec("mm_f3_2",  32'h0000_200F, ILL);
    vec("ecall",    32'h0000_0073, op(3'd0) | ECL);
    vec("ebreak",   32'h0010_0073, op(3'd0) | EBK);
    vec("wfi",      32'h1050_0073, ILL);
    vec("mret",     32'h3020_0073, e_mret);
    vec("csrrw",    32'h3400_1073, e_csrrw);
    vec("csrrsi",   32'h3400_6073, e_csrrsi);
    vec("csrrc",    32'h3400_3073, e_csrrc);
    vec("csrrci_x0", 32'h3400_7073, e_csrrci);
    vec("sys_f3_4", 32'h3400_4073, ILL);
    vec("low_bits", 32'h0000_0012, ILL);
    vec("bad_op",   32'h0000_007F, ILL);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
